dispensador_notas: RTL and testbench

Withdrawal dispenser stage downstream of the ATM session/payment datapath. It accepts a withdrawal request of 1–15 note units and checks it against a held 4-bit balance. An accepted request debits the balance and emits one `nota` pulse per unit at a fixed spacing, then waits for the customer to take the notes. If the notes are not taken, it retracts them and refunds the balance.

---
 rtl/dispensador_notas.sv | 210 +++++++++++++++++++++
 tb/tb_dispensador_notas.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_notas.sv
// dispensador_notas
// Withdrawal dispenser stage. Accepts a request of 1..15 note units, checks it
// against the held 4-bit balance, debits it, and emits one `nota` pulse per
// unit spaced NOTE_GAP idle cycles apart. Afterwards it either waits for the
// customer to take the notes (retract build) or completes directly.
//
// Parameters:
//   NOTE_GAP  idle cycles between consecutive nota pulses (>=1)
//   TIMEOUT   WAIT_TAKE cycles before retraction (2..511, retract build only)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   carrega_saldo, saldo_in     balance load (IDLE only)
//   pedido, valor               withdrawal request strobe and amount (IDLE only)
//   notas_retiradas             customer took the notes (WAIT_TAKE only)
//   saldo                       current balance
//   nota                        one-cycle pulse per dispensed unit
//   ocupado                     high in every state except IDLE
//   concluido/recusado/retido   one-cycle result pulses
//
// Build option: define DISPENSADOR_RETRACT_EN to enable WAIT_TAKE, the timeout
// counter, the refund and `retido`. Without it the block completes right after
// the last note and `retido` is tied to 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | accepts balance loads and requests
// CHECK     | compares latched valor with saldo, debits or rejects
// DISPENSE  | nota high for this cycle, one unit consumed
// GAP       | NOTE_GAP silent cycles between notes
// WAIT_TAKE | waits for notas_retiradas or timeout (retract build)
// END       | one cycle, result pulse registered on the way to IDLE

module dispensador_notas #(
  parameter int NOTE_GAP = 4,
  parameter int TIMEOUT  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carrega_saldo,
  input  logic [3:0] saldo_in,
  input  logic       pedido,
  input  logic [3:0] valor,
  input  logic       notas_retiradas,
  output logic [3:0] saldo,
  output logic       nota,
  output logic       ocupado,
  output logic       concluido,
  output logic       recusado,
  output logic       retido
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPENSE, S_GAP, S_WAIT_TAKE, S_END
  } state_t;

  localparam int GW = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(NOTE_GAP - 1);

  state_t          state_q, state_d;
  logic [3:0]      saldo_q, saldo_d;
  logic [3:0]      valor_q, valor_d;
  logic [3:0]      rest_q, rest_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            concluido_q, concluido_d;
  logic            recusado_q, recusado_d;

`ifdef DISPENSADOR_RETRACT_EN
  localparam logic [8:0] TMO_LAST = 9'(TIMEOUT - 1);
  logic [8:0] tmo_q, tmo_d;
  // Records which way WAIT_TAKE was left: 1 = taken, 0 = retracted.
  logic       taken_q, taken_d;
  logic       retido_q, retido_d;
`else
  logic unused_notas_retiradas;
  assign unused_notas_retiradas = notas_retiradas;
`endif

  always_comb begin
    state_d     = state_q;
    saldo_d     = saldo_q;
    valor_d     = valor_q;
    rest_d      = rest_q;
    gap_d       = gap_q;
    concluido_d = 1'b0;
    recusado_d  = 1'b0;
`ifdef DISPENSADOR_RETRACT_EN
    tmo_d       = tmo_q;
    taken_d     = taken_q;
    retido_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // A balance load in the same cycle drops the request.
        if (carrega_saldo) begin
          saldo_d = saldo_in;
        end else if (pedido) begin
          valor_d = valor;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (valor_q == 4'd0 || valor_q > saldo_q) begin
          recusado_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          saldo_d = saldo_q - valor_q;
          rest_d  = valor_q;
          state_d = S_DISPENSE;
        end
      end

      S_DISPENSE: begin
        rest_d = rest_q - 4'd1;
        if (rest_q == 4'd1) begin
`ifdef DISPENSADOR_RETRACT_EN
          tmo_d   = '0;
          state_d = S_WAIT_TAKE;
`else
          state_d = S_END;
`endif
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_DISPENSE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

`ifdef DISPENSADOR_RETRACT_EN
      S_WAIT_TAKE: begin
        tmo_d = tmo_q + 9'd1;
        // A take in the timeout cycle still counts as a take.
        if (notas_retiradas) begin
          taken_d = 1'b1;
          state_d = S_END;
        end else if (tmo_q == TMO_LAST) begin
          taken_d = 1'b0;
          saldo_d = saldo_q + valor_q;
          state_d = S_END;
        end
      end
`endif

      S_END: begin
`ifdef DISPENSADOR_RETRACT_EN
        if (taken_q) concluido_d = 1'b1;
        else         retido_d    = 1'b1;
`else
        concluido_d = 1'b1;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      saldo_q     <= '0;
      valor_q     <= '0;
      rest_q      <= '0;
      gap_q       <= '0;
      concluido_q <= 1'b0;
      recusado_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      saldo_q     <= saldo_d;
      valor_q     <= valor_d;
      rest_q      <= rest_d;
      gap_q       <= gap_d;
      concluido_q <= concluido_d;
      recusado_q  <= recusado_d;
    end
  end

`ifdef DISPENSADOR_RETRACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q    <= '0;
      taken_q  <= 1'b0;
      retido_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      taken_q  <= taken_d;
      retido_q <= retido_d;
    end
  end
  assign retido = retido_q;
`else
  assign retido = 1'b0;
`endif

  assign saldo     = saldo_q;
  assign nota      = (state_q == S_DISPENSE);
  assign ocupado   = (state_q != S_IDLE);
  assign concluido = concluido_q;
  assign recusado  = recusado_q;

endmodule

// File: tb/tb_dispensador_notas.sv
// Directed bench for dispensador_notas (NOTE_GAP=4, TIMEOUT=200).
// Inputs change and outputs are sampled just after the falling edge.

module tb_dispensador_notas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       carrega_saldo = 1'b0;
  logic [3:0] saldo_in = '0;
  logic       pedido = 1'b0;
  logic [3:0] valor = '0;
  logic       notas_retiradas = 1'b0;
  logic [3:0] saldo;
  logic       nota, ocupado, concluido, recusado, retido;

  int n_cmp = 0;
  int n_err = 0;

  dispensador_notas #(.NOTE_GAP(4), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst),
    .carrega_saldo(carrega_saldo), .saldo_in(saldo_in),
    .pedido(pedido), .valor(valor),
    .notas_retiradas(notas_retiradas),
    .saldo(saldo), .nota(nota), .ocupado(ocupado),
    .concluido(concluido), .recusado(recusado), .retido(retido)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] v);
    carrega_saldo = 1'b1;
    saldo_in      = v;
    step();
    carrega_saldo = 1'b0;
  endtask

  // Leaves the bench in the cycle after edge k (CHECK).
  task automatic req(input logic [3:0] v);
    pedido = 1'b1;
    valor  = v;
    step();
    pedido = 1'b0;
  endtask

  task automatic count_notes(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (nota) cnt++;
    end
  endtask

  // Called in the cycle of the last DISPENSE; completes by taking the notes.
  task automatic finish_take();
`ifdef DISPENSADOR_RETRACT_EN
    step();
    chk("wait_ocupado", ocupado, 1'b1);
    notas_retiradas = 1'b1;
    step();
    notas_retiradas = 1'b0;
    chk("end_concluido_low", concluido, 1'b0);
`else
    step();
    chk("end_concluido_low", concluido, 1'b0);
`endif
    step();
    chk("concluido", concluido, 1'b1);
    chk("done_ocupado", ocupado, 1'b0);
    chk("done_retido", retido, 1'b0);
    step();
    chk("concluido_drop", concluido, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [3:0] rej_vals [2];
    rej_vals[0] = 4'd5;
    rej_vals[1] = 4'd0;

    // Reset values
    step();
    chk("rst_saldo", saldo, 4'd0);
    chk("rst_nota", nota, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_concluido", concluido, 1'b0);
    chk("rst_recusado", recusado, 1'b0);
    chk("rst_retido", retido, 1'b0);
    rst = 1'b0;
    step();

    // Successful withdrawal: 7 - 3
    load(4'd7);
    chk("load_saldo", saldo, 4'd7);
    req(4'd3);
    chk("check_ocupado", ocupado, 1'b1);
    chk("check_saldo", saldo, 4'd7);
    valor = 4'd9;
    for (int i = 0; i <= 10; i++) begin
      step();
      chk("w3_nota", nota, (i % 5 == 0) ? 1'b1 : 1'b0);
      if (i == 0) chk("w3_saldo_debit", saldo, 4'd4);
    end
    finish_take();
    chk("w3_saldo_final", saldo, 4'd4);

    // Rejections: too large and zero
    foreach (rej_vals[j]) begin
      load(4'd2);
      req(rej_vals[j]);
      chk("rej_recusado_early", recusado, 1'b0);
      step();
      chk("rej_recusado", recusado, 1'b1);
      chk("rej_ocupado", ocupado, 1'b0);
      chk("rej_saldo", saldo, 4'd2);
      chk("rej_nota", nota, 1'b0);
      step();
      chk("rej_recusado_drop", recusado, 1'b0);
    end

    // Load and request together: load wins
    carrega_saldo = 1'b1;
    saldo_in      = 4'd9;
    pedido        = 1'b1;
    valor         = 4'd1;
    step();
    carrega_saldo = 1'b0;
    pedido        = 1'b0;
    chk("simul_saldo", saldo, 4'd9);
    chk("simul_ocupado", ocupado, 1'b0);
    step();
    chk("simul_ocupado2", ocupado, 1'b0);
    chk("simul_nota", nota, 1'b0);

    // 15 notes, with pedido/carrega_saldo pulsed during a GAP
    load(4'd15);
    req(4'd15);
    cnt = 0;
    for (int i = 1; i <= 71; i++) begin
      if (i == 3) begin
        pedido = 1'b1; valor = 4'd1; carrega_saldo = 1'b1; saldo_in = 4'd3;
      end else begin
        pedido = 1'b0; carrega_saldo = 1'b0;
      end
      step();
      if (nota) cnt++;
    end
    chk("w15_notes", cnt[15:0], 16'd15);
    chk("w15_saldo", saldo, 4'd0);
`ifdef DISPENSADOR_RETRACT_EN
    step();
    chk("tmo_ocupado", ocupado, 1'b1);
    for (int i = 0; i < 199; i++) step();
    chk("tmo_not_yet", retido, 1'b0);
    chk("tmo_saldo_pre", saldo, 4'd0);
    step();
    chk("tmo_refund", saldo, 4'd15);
    step();
    chk("retido", retido, 1'b1);
    chk("tmo_concluido", concluido, 1'b0);
    chk("tmo_ocupado_low", ocupado, 1'b0);
    step();
    chk("retido_drop", retido, 1'b0);

    // Take in the same cycle as the timeout
    load(4'd1);
    req(4'd1);
    step();
    chk("tt_nota", nota, 1'b1);
    step();
    for (int i = 0; i < 199; i++) step();
    notas_retiradas = 1'b1;
    step();
    notas_retiradas = 1'b0;
    chk("tt_no_refund", saldo, 4'd0);
    step();
    chk("tt_concluido", concluido, 1'b1);
    chk("tt_retido", retido, 1'b0);
    step();
`else
    step();
    chk("w15_end_concluido", concluido, 1'b0);
    step();
    chk("w15_concluido", concluido, 1'b1);
    chk("w15_retido", retido, 1'b0);
    chk("w15_saldo_kept", saldo, 4'd0);
    step();
`endif

    // Asynchronous reset after the second of 4 notes
    load(4'd10);
    req(4'd4);
    count_notes(7, cnt);
    chk("mid_notes", cnt[15:0], 16'd2);
    chk("mid_ocupado_pre", ocupado, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_nota", nota, 1'b0);
    chk("mid_rst_ocupado", ocupado, 1'b0);
    chk("mid_rst_saldo", saldo, 4'd0);
    step();
    rst = 1'b0;
    count_notes(20, cnt);
    chk("post_rst_notes", cnt[15:0], 16'd0);
    chk("post_rst_ocupado", ocupado, 1'b0);

    // Fresh transaction after reset
    load(4'd5);
    req(4'd2);
    count_notes(6, cnt);
    chk("fresh_notes", cnt[15:0], 16'd2);
    chk("fresh_saldo", saldo, 4'd3);
    finish_take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
